level_countdown_timer: RTL and testbench

Per-level game countdown timer. It consumes the one-cycle one-second tick produced by the slow-clock block and counts level time down from a loaded value. It adds bonus seconds on request and flags low time and expiry to game control and the score/HUD renderer. It also presents the remaining seconds as two BCD digits for on-screen display.

---
 rtl/timer_pkg.sv | 15 +
 rtl/sec_to_bcd.sv | 26 ++
 rtl/level_countdown_timer.sv | 124 ++++++++++++
 tb/tb_level_countdown_timer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and widths for the level countdown timer and its BCD helper.
// Holds the timer state enum and the binary/BCD digit widths.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      EXPIRED
   } timer_state_t;

   localparam int SECS_W = 7;
   localparam int BCD_W  = 4;

endpackage

// File: rtl/sec_to_bcd.sv
// Combinational 0..99 binary to two BCD digits, also used by the score display.
// Ports: bin (7-bit binary in), tens / ones (4-bit BCD digits out).
module sec_to_bcd
   import timer_pkg::*;
(
   input  logic [SECS_W-1:0] bin,
   output logic [BCD_W-1:0]  tens,
   output logic [BCD_W-1:0]  ones
);

   logic [SECS_W-1:0] base;

   // Constant compare chain: the last threshold met picks the tens digit.
   always_comb begin
      tens = '0;
      base = '0;
      for (int i = 1; i <= 9; i++) begin
         if (bin >= SECS_W'(i * 10)) begin
            tens = BCD_W'(i);
            base = SECS_W'(i * 10);
         end
      end
      ones = BCD_W'(bin - base);
   end

endmodule

// File: rtl/level_countdown_timer.sv
// Per-level countdown timer: loads START_SECS on start, counts down on tick,
// adds bonus seconds, flags low time / expiry and drives two BCD digits.
// Ports: clk, reset (async high), tick, start, pause, add_bonus in;
// secs_left, digit_tens, digit_ones, running, low_time, warn, expired out.
// Macro TIMER_WARN_BLINK_EN: warn blinks on accepted low-time ticks;
// otherwise warn simply mirrors low_time.
module level_countdown_timer
   import timer_pkg::*;
#(
   parameter int START_SECS = 60,
   parameter int BONUS_SECS = 10,
   parameter int MAX_SECS   = 99,
   parameter int LOW_THRESH = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              start,
   input  logic              pause,
   input  logic              add_bonus,
   output logic [SECS_W-1:0] secs_left,
   output logic [BCD_W-1:0]  digit_tens,
   output logic [BCD_W-1:0]  digit_ones,
   output logic              running,
   output logic              low_time,
   output logic              warn,
   output logic              expired
);

   timer_state_t      state;
   logic              tick_dec;
   logic              expire;
   logic [7:0]        run_sum;
   logic [7:0]        bonus_sum;
   logic [SECS_W-1:0] run_sat;
   logic [SECS_W-1:0] bonus_sat;

   function automatic logic is_low(input logic [SECS_W-1:0] v);
      return (v != '0) && (v <= SECS_W'(LOW_THRESH));
   endfunction

   // Guard the decrement so a zero count can never wrap.
   assign tick_dec = tick && (secs_left != '0);
   assign expire   = tick && !add_bonus && (secs_left == SECS_W'(1));

   always_comb begin
      bonus_sum = {1'b0, secs_left} + 8'(BONUS_SECS);
      run_sum   = {1'b0, secs_left} - {7'd0, tick_dec}
                + (add_bonus ? 8'(BONUS_SECS) : 8'd0);
      run_sat   = (run_sum > 8'(MAX_SECS)) ?
                  SECS_W'(MAX_SECS) : run_sum[SECS_W-1:0];
      bonus_sat = (bonus_sum > 8'(MAX_SECS)) ?
                  SECS_W'(MAX_SECS) : bonus_sum[SECS_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         secs_left <= '0;
         expired   <= 1'b0;
`ifdef TIMER_WARN_BLINK_EN
         warn      <= 1'b0;
`endif
      end else begin
         expired <= 1'b0;
         if (start) begin
            secs_left <= SECS_W'(START_SECS);
            state     <= pause ? PAUSED : RUN;
`ifdef TIMER_WARN_BLINK_EN
            warn      <= 1'b0;
`endif
         end else begin
            unique case (state)
               RUN: begin
                  if (pause) begin
                     state <= PAUSED;
                  end else if (expire) begin
                     secs_left <= '0;
                     state     <= EXPIRED;
                     expired   <= 1'b1;
`ifdef TIMER_WARN_BLINK_EN
                     warn      <= 1'b0;
`endif
                  end else begin
                     secs_left <= run_sat;
`ifdef TIMER_WARN_BLINK_EN
                     if (!is_low(run_sat))
                        warn <= 1'b0;
                     else if (tick && low_time)
                        warn <= ~warn;
`endif
                  end
               end
               PAUSED: begin
                  if (add_bonus) begin
                     secs_left <= bonus_sat;
`ifdef TIMER_WARN_BLINK_EN
                     if (!is_low(bonus_sat))
                        warn <= 1'b0;
`endif
                  end
                  if (!pause)
                     state <= RUN;
               end
               default: ;
            endcase
         end
      end
   end

   assign running  = (state == RUN) || (state == PAUSED);
   assign low_time = running && is_low(secs_left);

`ifndef TIMER_WARN_BLINK_EN
   assign warn = low_time;
`endif

   sec_to_bcd u_bcd (
      .bin  (secs_left),
      .tens (digit_tens),
      .ones (digit_ones)
   );

endmodule

// File: tb/tb_level_countdown_timer.sv
// Directed bench for level_countdown_timer: vector table plus
// hand-written sequences for expiry, bonus-at-one, restart and reset.
module tb_level_countdown_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick, start, pause, add_bonus;
   logic [6:0] secs_left;
   logic [3:0] digit_tens, digit_ones;
   logic       running, low_time, warn, expired;

   int checks = 0;
   int errors = 0;

`ifdef TIMER_WARN_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   level_countdown_timer dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .start      (start),
      .pause      (pause),
      .add_bonus  (add_bonus),
      .secs_left  (secs_left),
      .digit_tens (digit_tens),
      .digit_ones (digit_ones),
      .running    (running),
      .low_time   (low_time),
      .warn       (warn),
      .expired    (expired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic s, p, t, b;
      int   secs;
      logic run, low, exp;
   } vec_t;

   vec_t tv[29];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int secs,
                          input logic run, input logic low,
                          input logic exp);
      chk({nm, "_secs"}, int'(secs_left), secs);
      chk({nm, "_tens"}, int'(digit_tens), secs / 10);
      chk({nm, "_ones"}, int'(digit_ones), secs % 10);
      chk({nm, "_run"}, int'(running), int'(run));
      chk({nm, "_low"}, int'(low_time), int'(low));
      chk({nm, "_exp"}, int'(expired), int'(exp));
   endtask

   task automatic step(input logic s, input logic p,
                       input logic t, input logic b);
      @(negedge clk);
      start = s; pause = p; tick = t; add_bonus = b;
      @(posedge clk);
      #1;
      start = 1'b0; tick = 1'b0; add_bonus = 1'b0;
   endtask

   initial begin
      tv[0]  = '{0,0,1,0,  0, 0,0,0};
      tv[1]  = '{0,0,0,1,  0, 0,0,0};
      tv[2]  = '{1,0,0,0, 60, 1,0,0};
      tv[3]  = '{0,0,1,0, 59, 1,0,0};
      tv[4]  = '{0,0,1,0, 58, 1,0,0};
      tv[5]  = '{0,0,1,0, 57, 1,0,0};
      tv[6]  = '{0,1,1,0, 57, 1,0,0};
      tv[7]  = '{0,1,1,0, 57, 1,0,0};
      tv[8]  = '{0,1,1,0, 57, 1,0,0};
      tv[9]  = '{0,1,0,1, 67, 1,0,0};
      tv[10] = '{0,0,0,0, 67, 1,0,0};
      tv[11] = '{0,0,1,0, 66, 1,0,0};
      tv[12] = '{0,0,0,1, 76, 1,0,0};
      tv[13] = '{0,0,1,1, 85, 1,0,0};
      tv[14] = '{1,0,1,0, 60, 1,0,0};
      tv[15] = '{0,0,0,1, 70, 1,0,0};
      tv[16] = '{0,0,0,1, 80, 1,0,0};
      tv[17] = '{0,0,0,1, 90, 1,0,0};
      tv[18] = '{0,0,0,1, 99, 1,0,0};
      tv[19] = '{0,0,1,0, 98, 1,0,0};
      tv[20] = '{0,0,1,0, 97, 1,0,0};
      tv[21] = '{0,0,1,0, 96, 1,0,0};
      tv[22] = '{0,0,1,0, 95, 1,0,0};
      tv[23] = '{0,0,0,1, 99, 1,0,0};
      tv[24] = '{0,0,0,1, 99, 1,0,0};
      tv[25] = '{1,1,1,0, 60, 1,0,0};
      tv[26] = '{0,1,0,1, 70, 1,0,0};
      tv[27] = '{0,0,1,0, 70, 1,0,0};
      tv[28] = '{0,0,1,0, 69, 1,0,0};

      reset = 1'b1;
      tick = 1'b0; start = 1'b0; pause = 1'b0; add_bonus = 1'b0;
      #12;
      chk_all("rst", 0, 0, 0, 0);
      chk("rst_warn", int'(warn), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 29; i++) begin
         step(tv[i].s, tv[i].p, tv[i].t, tv[i].b);
         chk_all($sformatf("v%0d", i), tv[i].secs,
                 tv[i].run, tv[i].low, tv[i].exp);
         chk($sformatf("v%0d_warn", i), int'(warn), 0);
      end

      // Count down to low time, through expiry and beyond.
      step(1, 0, 0, 0);
      for (int i = 0; i < 50; i++) step(0, 0, 1, 0);
      chk_all("low10", 10, 1, 1, 0);
      chk("low10_warn", int'(warn), BLINK ? 0 : 1);
      step(0, 0, 1, 0);
      chk_all("low9", 9, 1, 1, 0);
      chk("low9_warn", int'(warn), 1);
      step(0, 0, 1, 0);
      chk("low8_warn", int'(warn), BLINK ? 0 : 1);
      step(0, 0, 1, 0);
      chk_all("low7", 7, 1, 1, 0);
      chk("low7_warn", int'(warn), 1);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
      chk_all("one", 1, 1, 1, 0);
      step(0, 0, 1, 0);
      chk_all("expire", 0, 0, 0, 1);
      chk("expire_warn", int'(warn), 0);
      step(0, 0, 0, 0);
      chk_all("post_exp", 0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      step(0, 1, 1, 0);
      chk_all("exp_hold", 0, 0, 0, 0);

      // Start out of EXPIRED with pause held lands in PAUSED.
      step(1, 1, 0, 0);
      chk_all("restart", 60, 1, 0, 0);
      chk("restart_warn", int'(warn), 0);
      step(0, 0, 1, 0);
      chk_all("unpause", 60, 1, 0, 0);
      step(0, 0, 1, 0);
      chk_all("unpause_tick", 59, 1, 0, 0);

      // Tick plus bonus at one second: bonus wins, no expiry.
      for (int i = 0; i < 58; i++) step(0, 0, 1, 0);
      chk_all("b_one", 1, 1, 1, 0);
      step(0, 0, 1, 1);
      chk_all("b_save", 10, 1, 1, 0);
      step(0, 0, 0, 0);
      chk("b_save_noexp", int'(expired), 0);

      // Start with a simultaneous tick mid-count.
      step(1, 0, 0, 0);
      for (int i = 0; i < 37; i++) step(0, 0, 1, 0);
      chk_all("mid23", 23, 1, 0, 0);
      step(1, 0, 1, 0);
      chk_all("mid_start", 60, 1, 0, 0);
      chk("mid_start_warn", int'(warn), 0);

      // Asynchronous reset between edges.
      step(0, 0, 1, 0);
      #2;
      reset = 1'b1;
      #1;
      chk_all("arst", 0, 0, 0, 0);
      chk("arst_warn", int'(warn), 0);
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 1, 0);
      chk_all("arst_idle", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
